// File: rtl/prog_launcher_pkg.sv
// Shared state encoding, default timing constants and helpers for the program launcher.
package prog_launcher_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_RST   = 3'd1;
    localparam state_t ST_START = 3'd2;
    localparam state_t ST_RUN   = 3'd3;
    localparam state_t ST_LOG   = 3'd4;
    localparam state_t ST_DONE  = 3'd5;
    localparam state_t ST_FAIL  = 3'd6;

    localparam int          DEF_RST_CYC     = 2;
    localparam int          DEF_START_CYC   = 2;
    localparam logic [15:0] DEF_TIMEOUT_CYC = 16'd4000;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/prog_launcher_pulse_timer.sv
// Down-counting pulse timer: load a width, then expired flags the final cycle of the pulse.
module pulse_timer (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic        expired
);

    logic [15:0] count;

    always_ff @(posedge Clk) begin
        if (Reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 16'd1;
    end

    // A zero-width load behaves as a single cycle rather than hanging.
    assign expired = (count <= 16'd1);

endmodule

// File: rtl/prog_launcher.sv
// Sequences reset/start pulses to a processor core for up to three programs and logs run times.
module prog_launcher
    import prog_launcher_pkg::*;
#(
    parameter int          RST_CYC     = DEF_RST_CYC,
    parameter int          START_CYC   = DEF_START_CYC,
    parameter logic [15:0] TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Go,
    input  logic [1:0]  NumProgs,
    output logic        DutReset,
    output logic        DutStart,
    input  logic        DutAck,
    output logic [1:0]  ProgIdx,
    output logic [15:0] LastCycles,
    output logic        LastValid,
    output logic        Done,
    output logic        Timeout
);

    localparam logic [15:0] RST_LOAD   = 16'(RST_CYC);
    localparam logic [15:0] START_LOAD = 16'(START_CYC);

    state_t      state;
    state_t      next_state;
    logic [1:0]  num_latched;
    logic [15:0] counter;
    logic        go_accept;
    logic        acked;
    logic        last_prog;
    logic        timer_load;
    logic [15:0] timer_val;
    logic        timer_expired;

    assign go_accept = Go && ((state == ST_IDLE) || (state == ST_DONE));
    assign acked     = (state == ST_RUN) && DutAck;
    assign last_prog = (({1'b0, ProgIdx} + 3'd1) == {1'b0, num_latched});

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE: if (Go) next_state = (NumProgs == 2'd0) ? ST_DONE : ST_RST;
            ST_RST:           if (timer_expired) next_state = ST_START;
            ST_START:         if (timer_expired) next_state = ST_RUN;
            ST_RUN: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (DutAck)
                    next_state = ST_LOG;
                else if (counter == TIMEOUT_CYC)
                    next_state = ST_FAIL;
            end
            ST_LOG:           next_state = last_prog ? ST_DONE : ST_START;
            ST_FAIL:          next_state = ST_FAIL;
            default:          next_state = ST_IDLE;
        endcase
    end

    assign timer_load = ((next_state == ST_RST) && (state != ST_RST)) ||
                        ((next_state == ST_START) && (state != ST_START));
    assign timer_val  = (next_state == ST_RST) ? RST_LOAD : START_LOAD;

    pulse_timer u_pulse_timer (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (timer_expired)
    );

    // Core-facing strobes are flopped from the next state so they never glitch.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= ST_IDLE;
            DutReset    <= 1'b0;
            DutStart    <= 1'b0;
            Done        <= 1'b0;
            Timeout     <= 1'b0;
            LastValid   <= 1'b0;
            LastCycles  <= '0;
            ProgIdx     <= '0;
            num_latched <= '0;
        end else begin
            state     <= next_state;
            DutReset  <= (next_state == ST_RST) || (next_state == ST_FAIL);
            DutStart  <= (next_state == ST_START);
            Done      <= (next_state == ST_DONE);
            LastValid <= acked;
            if (next_state == ST_FAIL)
                Timeout <= 1'b1;
            if (acked)
                LastCycles <= counter;
            if (go_accept) begin
                num_latched <= NumProgs;
                ProgIdx     <= '0;
            end else if ((state == ST_LOG) && !last_prog) begin
                ProgIdx <= ProgIdx + 2'd1;
            end
        end
    end

    // RUN-cycle counter: reads 1 in the first RUN cycle and freezes on the ack cycle.
    always_ff @(posedge Clk) begin
        if (Reset)
            counter <= '0;
        else if (state == ST_RUN) begin
            if (!DutAck)
                counter <= sat_inc(counter);
        end else if (next_state == ST_RUN)
            counter <= 16'd1;
        else if (state == ST_LOG)
            counter <= '0;
    end

endmodule

// File: tb/tb_prog_launcher.sv
// Self-checking bench for prog_launcher with a reactive core model and a sequence-level reference.
module tb_prog_launcher;

    localparam int RST_CYC   = 2;
    localparam int START_CYC = 2;
    localparam int TMO       = 20;
    localparam int NEVER     = 1000;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Go;
    logic [1:0]  NumProgs;
    logic        DutReset;
    logic        DutStart;
    logic        DutAck;
    logic [1:0]  ProgIdx;
    logic [15:0] LastCycles;
    logic        LastValid;
    logic        Done;
    logic        Timeout;

    prog_launcher #(
        .RST_CYC     (RST_CYC),
        .START_CYC   (START_CYC),
        .TIMEOUT_CYC (16'd20)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Go         (Go),
        .NumProgs   (NumProgs),
        .DutReset   (DutReset),
        .DutStart   (DutStart),
        .DutAck     (DutAck),
        .ProgIdx    (ProgIdx),
        .LastCycles (LastCycles),
        .LastValid  (LastValid),
        .Done       (Done),
        .Timeout    (Timeout)
    );

    always #5 Clk = ~Clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Per-program ack delay in RUN cycles, as seen by the core model.
    int delays[3];

    // Observations of the most recent sequence.
    int obs_rst_pulses, obs_rst_len, obs_start_pulses, obs_start_len_bad, obs_overlap, obs_fail_run;
    int obs_vals[$];
    int obs_idx[$];
    bit obs_done, obs_timeout, obs_aborted, obs_budget_out, obs_first_done;

    // Reference outcome: programs finish in order with their own delays until one exceeds the limit.
    int exp_vals[$];
    int exp_starts, exp_rst_pulses, exp_rst_len;
    bit exp_done, exp_timeout;

    task automatic build_model(input int num);
        exp_vals.delete();
        exp_timeout    = 0;
        exp_starts     = 0;
        exp_rst_pulses = (num > 0) ? 1 : 0;
        exp_rst_len    = (num > 0) ? RST_CYC : 0;
        for (int i = 0; i < num; i++) begin
            exp_starts++;
            if (delays[i] > TMO) begin
                exp_timeout = 1;
                break;
            end
            exp_vals.push_back(delays[i]);
        end
        exp_done = !exp_timeout;
    endtask

    // Issues Go, plays the core (ack after delays[prog] RUN cycles) and records what the launcher does.
    task automatic drive_sequence(input logic [1:0] num, input bit noise, input int abort_prog, input int abort_run);
        bit prev_start = 0;
        bit prev_rst   = 0;
        bit running    = 0;
        int run_k      = 0;
        int start_len  = 0;
        int prog;
        obs_rst_pulses = 0; obs_rst_len = 0; obs_start_pulses = 0; obs_start_len_bad = 0;
        obs_overlap = 0; obs_fail_run = 0; obs_vals.delete(); obs_idx.delete();
        obs_done = 0; obs_timeout = 0; obs_aborted = 0; obs_budget_out = 1; obs_first_done = 0;
        @(negedge Clk);
        NumProgs = num;
        Go       = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge Clk);
            Go = 1'b0;
            if (cyc == 0) obs_first_done = Done;
            if (DutReset && DutStart) obs_overlap++;
            if (DutReset && !prev_rst && !Timeout) obs_rst_pulses++;
            if (DutReset && !Timeout) obs_rst_len++;
            if (DutStart) begin
                if (!prev_start) begin
                    obs_start_pulses++;
                    start_len = 0;
                end
                start_len++;
            end else if (prev_start) begin
                if (start_len != START_CYC) obs_start_len_bad++;
                running = 1;
                run_k   = 0;
            end
            if (running && !DutReset && !Timeout) run_k++;
            if (LastValid) begin
                obs_vals.push_back(int'(LastCycles));
                obs_idx.push_back(int'(ProgIdx));
            end
            if (Timeout) begin
                obs_timeout = 1; obs_fail_run = run_k; obs_budget_out = 0;
                break;
            end
            if (Done) begin
                obs_done = 1; obs_budget_out = 0;
                break;
            end
            prog = obs_start_pulses - 1;
            if (running && prog == abort_prog && run_k == abort_run) begin
                Reset = 1'b1; DutAck = 1'b0; obs_aborted = 1; obs_budget_out = 0;
                break;
            end
            DutAck = 1'b0;
            if (noise && (DutReset || DutStart)) DutAck = 1'b1;
            if (running && prog >= 0 && prog < 3 && run_k == delays[prog]) begin
                DutAck  = 1'b1;
                running = 0;
            end
            prev_start = DutStart;
            prev_rst   = DutReset;
        end
        DutAck = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Go = 1'b0; DutAck = 1'b0; NumProgs = 2'd0;
        repeat (3) @(negedge Clk);
        tests_run++; if (DutReset !== 1'b0)   begin tests_failed++; $display("[TB] FAIL reset_dutreset got %b want 0", DutReset); end
        tests_run++; if (DutStart !== 1'b0)   begin tests_failed++; $display("[TB] FAIL reset_dutstart got %b want 0", DutStart); end
        tests_run++; if (ProgIdx !== 2'd0)    begin tests_failed++; $display("[TB] FAIL reset_progidx got %0d want 0", ProgIdx); end
        tests_run++; if (LastCycles !== 16'd0) begin tests_failed++; $display("[TB] FAIL reset_lastcycles got %0d want 0", LastCycles); end
        tests_run++; if (LastValid !== 1'b0)  begin tests_failed++; $display("[TB] FAIL reset_lastvalid got %b want 0", LastValid); end
        tests_run++; if (Done !== 1'b0)       begin tests_failed++; $display("[TB] FAIL reset_done got %b want 0", Done); end
        tests_run++; if (Timeout !== 1'b0)    begin tests_failed++; $display("[TB] FAIL reset_timeout got %b want 0", Timeout); end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_single();
        delays = '{10, NEVER, NEVER};
        build_model(1);
        drive_sequence(2'd1, 0, -1, 0);
        tests_run++; if (obs_rst_len != RST_CYC) begin tests_failed++; $display("[TB] FAIL single_rst_len got %0d want %0d", obs_rst_len, RST_CYC); end
        tests_run++; if (obs_start_pulses != 1 || obs_start_len_bad != 0) begin tests_failed++; $display("[TB] FAIL single_start got %0d pulses %0d bad want 1 pulse 0 bad", obs_start_pulses, obs_start_len_bad); end
        tests_run++; if (obs_vals.size() != 1 || obs_vals[0] != 10) begin tests_failed++; $display("[TB] FAIL single_lastcycles got %0d pulses (first %0d) want 1 pulse of 10", obs_vals.size(), (obs_vals.size() > 0) ? obs_vals[0] : -1); end
        tests_run++; if (!obs_done || ProgIdx !== 2'd0) begin tests_failed++; $display("[TB] FAIL single_done got done=%b idx=%0d want done=1 idx=0", obs_done, ProgIdx); end
    endtask

    task automatic test_multi();
        delays = '{5, 7, 9};
        build_model(3);
        drive_sequence(2'd3, 0, -1, 0);
        tests_run++; if (obs_first_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL multi_done_clears got %b want 0", obs_first_done); end
        tests_run++; if (obs_rst_pulses != 1) begin tests_failed++; $display("[TB] FAIL multi_rst_once got %0d want 1", obs_rst_pulses); end
        tests_run++; if (obs_vals.size() != 3) begin tests_failed++; $display("[TB] FAIL multi_pulses got %0d want 3", obs_vals.size()); end
        for (int i = 0; i < 3 && i < obs_vals.size(); i++) begin
            tests_run++;
            if (obs_vals[i] != exp_vals[i] || obs_idx[i] != i) begin
                tests_failed++;
                $display("[TB] FAIL multi_prog%0d got val=%0d idx=%0d want val=%0d idx=%0d", i, obs_vals[i], obs_idx[i], exp_vals[i], i);
            end
        end
        tests_run++; if (!obs_done || ProgIdx !== 2'd2 || LastCycles !== 16'd9) begin tests_failed++; $display("[TB] FAIL multi_final got done=%b idx=%0d last=%0d want 1/2/9", obs_done, ProgIdx, LastCycles); end
    endtask

    task automatic test_random();
        int num;
        for (int it = 0; it < 10; it++) begin
            num = $urandom_range(1, 3);
            for (int i = 0; i < 3; i++) delays[i] = $urandom_range(1, 22);
            if (it == 0) delays[0] = TMO;
            build_model(num);
            drive_sequence(2'(num), $urandom_range(0, 1), -1, 0);
            tests_run++;
            if (obs_budget_out || obs_done != exp_done || obs_timeout != exp_timeout) begin
                tests_failed++;
                $display("[TB] FAIL random%0d_outcome got done=%b timeout=%b stuck=%b want done=%b timeout=%b", it, obs_done, obs_timeout, obs_budget_out, exp_done, exp_timeout);
            end
            tests_run++;
            if (obs_start_pulses != exp_starts || obs_rst_pulses != exp_rst_pulses || obs_rst_len != exp_rst_len || obs_overlap != 0 || obs_start_len_bad != 0) begin
                tests_failed++;
                $display("[TB] FAIL random%0d_strobes got starts=%0d rsts=%0d rstlen=%0d overlap=%0d badlen=%0d want %0d/%0d/%0d/0/0", it, obs_start_pulses, obs_rst_pulses, obs_rst_len, obs_overlap, obs_start_len_bad, exp_starts, exp_rst_pulses, exp_rst_len);
            end
            tests_run++;
            if (obs_vals != exp_vals) begin
                tests_failed++;
                $display("[TB] FAIL random%0d_values got %p want %p", it, obs_vals, exp_vals);
            end
            if (exp_timeout) begin
                tests_run++;
                if (obs_fail_run != TMO) begin tests_failed++; $display("[TB] FAIL random%0d_fail_run got %0d want %0d", it, obs_fail_run, TMO); end
                Reset = 1'b1;
                @(negedge Clk);
                Reset = 1'b0;
            end
        end
    endtask

    task automatic test_timeout();
        delays = '{NEVER, NEVER, NEVER};
        drive_sequence(2'd1, 0, -1, 0);
        tests_run++; if (!obs_timeout || obs_fail_run != TMO) begin tests_failed++; $display("[TB] FAIL timeout_entry got timeout=%b run=%0d want 1/%0d", obs_timeout, obs_fail_run, TMO); end
        tests_run++; if (DutReset !== 1'b1 || obs_vals.size() != 0) begin tests_failed++; $display("[TB] FAIL timeout_outputs got dutreset=%b pulses=%0d want 1/0", DutReset, obs_vals.size()); end
        NumProgs = 2'd0;
        Go = 1'b1;
        repeat (3) @(negedge Clk);
        Go = 1'b0;
        @(negedge Clk);
        tests_run++; if (Timeout !== 1'b1 || DutReset !== 1'b1 || DutStart !== 1'b0 || Done !== 1'b0) begin tests_failed++; $display("[TB] FAIL timeout_go_ignored got T=%b R=%b S=%b D=%b want 1/1/0/0", Timeout, DutReset, DutStart, Done); end
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        tests_run++; if (Timeout !== 1'b0 || DutReset !== 1'b0 || Done !== 1'b0 || LastCycles !== 16'd0) begin tests_failed++; $display("[TB] FAIL timeout_reset_clears got T=%b R=%b D=%b last=%0d want 0/0/0/0", Timeout, DutReset, Done, LastCycles); end
    endtask

    task automatic test_ack_in_start();
        delays = '{3, NEVER, NEVER};
        drive_sequence(2'd1, 1, -1, 0);
        tests_run++; if (obs_vals.size() != 1 || LastCycles !== 16'd3 || !obs_done) begin tests_failed++; $display("[TB] FAIL ack_in_start got pulses=%0d last=%0d done=%b want 1/3/1", obs_vals.size(), LastCycles, obs_done); end
    endtask

    task automatic test_reset_mid_run();
        delays = '{4, NEVER, NEVER};
        drive_sequence(2'd2, 0, 1, 5);
        tests_run++; if (!obs_aborted || obs_vals.size() != 1) begin tests_failed++; $display("[TB] FAIL midrun_reached got aborted=%b pulses=%0d want 1/1", obs_aborted, obs_vals.size()); end
        @(negedge Clk);
        Reset = 1'b0;
        tests_run++;
        if (DutReset !== 1'b0 || DutStart !== 1'b0 || ProgIdx !== 2'd0 || LastCycles !== 16'd0 || LastValid !== 1'b0 || Done !== 1'b0 || Timeout !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrun_cleared got R=%b S=%b idx=%0d last=%0d V=%b D=%b T=%b want all 0", DutReset, DutStart, ProgIdx, LastCycles, LastValid, Done, Timeout);
        end
        delays = '{6, 8, NEVER};
        drive_sequence(2'd2, 0, -1, 0);
        tests_run++; if (obs_vals.size() != 2 || obs_idx[0] != 0 || obs_vals[0] != 6 || obs_vals[1] != 8) begin tests_failed++; $display("[TB] FAIL midrun_rerun got %p idx %p want '{6,8} idx '{0,1}", obs_vals, obs_idx); end
    endtask

    task automatic test_zero_progs();
        drive_sequence(2'd0, 0, -1, 0);
        tests_run++; if (obs_first_done !== 1'b1) begin tests_failed++; $display("[TB] FAIL zero_done_next got %b want 1", obs_first_done); end
        tests_run++; if (obs_rst_pulses != 0 || obs_start_pulses != 0 || ProgIdx !== 2'd0) begin tests_failed++; $display("[TB] FAIL zero_no_strobes got rst=%0d start=%0d idx=%0d want 0/0/0", obs_rst_pulses, obs_start_pulses, ProgIdx); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_zero_progs();
        test_ack_in_start();
        test_timeout();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/prog_launcher.md
PROG_LAUNCHER -- requirements
Module: prog_launcher

Interface
REQ-001 SHALL have parameter RST_CYC, default 2: cycles DutReset is held high before the first program.
REQ-002 SHALL have parameter START_CYC, default 2: cycles DutStart is held high per program.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 16'd4000: RUN-cycle limit before abort.
REQ-004 Clk  in  1  clock; all logic on posedge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 Go  in  1  request to run a program sequence; sampled in IDLE and DONE only.
REQ-007 NumProgs  in  2  number of programs to run (0..3); sampled on accepted Go.
REQ-008 DutReset  out  1  reset to the processor core.
REQ-009 DutStart  out  1  start to the processor core.
REQ-010 DutAck  in  1  done flag from the processor core.
REQ-011 ProgIdx  out  2  index of the current or last program.
REQ-012 LastCycles  out  16  RUN-cycle count of the last completed program.
REQ-013 LastValid  out  1  one-cycle pulse when LastCycles updates.
REQ-014 Done  out  1  sequence finished normally; level.
REQ-015 Timeout  out  1  sticky abort flag.

Function
REQ-016 States SHALL be IDLE, RST, START, RUN, LOG, DONE, FAIL.
REQ-017 IDLE/DONE + Go: with NumProgs=0, go to DONE and set ProgIdx=0; otherwise latch NumProgs, set ProgIdx=0 and go to RST.
REQ-018 RST: DutReset=1 for exactly RST_CYC cycles, then go to START.
REQ-019 START: DutStart=1 for exactly START_CYC cycles, then go to RUN.
REQ-020 RUN: DutStart=0 and DutReset=0; the counter starts at 1 in the first RUN cycle and increments once per cycle, saturating at 16'hFFFF.
REQ-021 DutAck SHALL be ignored in every state except RUN.
REQ-022 RUN + DutAck=1: go to LOG, and the counter SHALL NOT increment that cycle.
REQ-023 LOG (one cycle): LastCycles <= counter and LastValid=1. If ProgIdx+1 == latched NumProgs, go to DONE; otherwise increment ProgIdx, clear the counter and go to START (no DutReset between programs).
REQ-024 RUN + counter == TIMEOUT_CYC + no DutAck: go to FAIL and set Timeout=1.
REQ-025 If DutAck arrives in the same cycle the counter reaches TIMEOUT_CYC, Ack wins and the block goes to LOG.
REQ-026 DONE: Done=1; LastCycles and ProgIdx hold. Go restarts the sequence per REQ-017, with Done cleared on the next cycle.
REQ-027 FAIL: Timeout=1; DutReset=1 continuously; Go ignored. Exit only via Reset.
REQ-028 Go while in RST/START/RUN/LOG SHALL be ignored.
REQ-029 DutReset and DutStart SHALL be registered outputs (glitch-free) and are never both 1.

Reset
REQ-030 Reset SHALL force IDLE, DutReset=0, DutStart=0, ProgIdx=0, LastCycles=0, LastValid=0, Done=0, Timeout=0, counter=0.
REQ-031 Reset mid-sequence SHALL abandon it immediately; no LastValid pulse for the interrupted program.

Structure
REQ-032 The state enum and default constants (RST_CYC, START_CYC, TIMEOUT_CYC) SHALL live in shared package prog_launcher_pkg.
REQ-033 The RST/START pulse widths SHALL come from one sub-module, pulse_timer: load value, count down, expired flag.
REQ-034 The RUN counter SHALL be a separate 16-bit saturating counter inside prog_launcher.

Verification
REQ-035 NumProgs=1, Go pulse, DUT model acks 10 cycles after DutStart falls: expect DutReset high 2 cycles, DutStart high 2 cycles, then LastCycles=10, one LastValid pulse, Done=1, ProgIdx=0.
REQ-036 NumProgs=3, acks after 5/7/9 RUN cycles: expect three LastValid pulses with values 5, 7, 9; ProgIdx 0 -> 1 -> 2; DutReset asserted only once; Done=1.
REQ-037 TIMEOUT_CYC=20, no Ack: expect FAIL after 20 RUN cycles with Timeout=1 and DutReset=1; Go ignored; Reset clears everything.
REQ-038 DutAck held high during START and asserted again after 3 RUN cycles: expect Ack ignored in START and LastCycles=3.
REQ-039 Reset asserted mid-RUN of program 1 of 2: expect all outputs at reset values next cycle, no LastValid, and a fresh Go rerunning from ProgIdx=0.
REQ-040 NumProgs=0 with Go: expect Done=1 next cycle, with DutReset and DutStart never asserted.
